// File: rtl/sram_pkg.sv
// Shared types and constants for the two-halfword SRAM responder.
package sram_pkg;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} sram_state_t;

  localparam int          SRAM_DATA_W       = 16;
  localparam int          SRAM_ADDR_W       = 18;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: `first` marks the address-setup cycle, `last` the exit/sample cycle.
module sram_wait_counter
  import sram_pkg::*;
#(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] tc,
  output logic             first,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || load) cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end

  assign first = (cnt == '0);
  assign last  = (cnt == tc);

endmodule

// File: rtl/sram_controller.sv
// 32-bit word access over a 16-bit async SRAM as two half-accesses (low half, then high half).
// Optional range check enabled by defining SRAM_ADDR_CHECK_EN.
module sram_controller
  import sram_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic                   err,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam int               CNT_W = $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] TC    = CNT_W'(WAIT_CYCLES - 1);

  sram_state_t            state, state_nxt;
  logic                   req, oor, is_wr, first, last, load, dq_oe;
  logic [31:0]            off, wdata;
  logic [SRAM_DATA_W-1:0] dq_out, rd_lo;
  logic                   unused_off;

  assign req        = wr_en | rd_en;
  assign off        = address - BASE_ADDR;
  assign unused_off = ^{off[31:19], off[1:0]};

`ifdef SRAM_ADDR_CHECK_EN
  assign oor = (address < BASE_ADDR) || (off[31:19] != '0);
`else
  assign oor = 1'b0;
`endif

  // Counter restarts at every phase entry, so cnt==0 is always the setup cycle.
  assign load = (state == IDLE) || (state == DONE) || last;

  sram_wait_counter #(.CNT_W(CNT_W)) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .tc   (TC),
    .first(first),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = oor ? DONE : LO;
      LO:      if (last) state_nxt = HI;
      HI:      if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = wdata[15:0];
    case (state)
      IDLE: ready = !req;
      LO: begin
        dq_oe     = is_wr;
        SRAM_WE_N = !(is_wr && !first);
      end
      HI: begin
        dq_oe     = is_wr;
        dq_out    = wdata[31:16];
        SRAM_WE_N = !(is_wr && !first);
      end
      default: ready = 1'b1;
    endcase
  end

  // SRAM_ADDR is held after the access so it never moves while WE_N is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
      SRAM_ADDR <= '0;
      is_wr     <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        is_wr <= wr_en;
        if (!oor) SRAM_ADDR <= {off[18:2], 1'b0};
`ifdef SRAM_ADDR_CHECK_EN
        if (oor && !wr_en) read_data <= '0;
`endif
      end
      if (state == LO && last) SRAM_ADDR[0] <= 1'b1;
      if (state == HI && last && !is_wr) read_data <= {SRAM_DQ, rd_lo};
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req) wdata <= write_data;
    if (state == LO && last && !is_wr) rd_lo <= SRAM_DQ;
  end

`ifdef SRAM_ADDR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                               err <= 1'b0;
    else if (state == IDLE && req && oor)  err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  assign SRAM_DQ   = dq_oe ? dq_out : 'z;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule
